// File: rtl/pipelined_alu_cc.sv
// ============================================================================
//  Module   : pipelined_alu_cc
//  Purpose  : Two-stage Y86 execute ALU (add/sub/and/xor) with valid/ready
//             handshakes and an architectural ZF/SF/OF condition-code register.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_alu_cc #(
   parameter int         WIDTH    = 64,
   parameter logic [2:0] CC_RESET = 3'b100
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] num1,
   input  logic [WIDTH-1:0] num2,
   input  logic [1:0]       operation,
   input  logic             set_cc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             overflow_flag,
   output logic             zero_flag,
   output logic             sign_flag,
   output logic             cc_zf,
   output logic             cc_sf,
   output logic             cc_of
);

   localparam logic [1:0] c_op_add = 2'b00;
   localparam logic [1:0] c_op_sub = 2'b01;
   localparam logic [1:0] c_op_and = 2'b10;
   localparam logic [1:0] c_op_xor = 2'b11;

   logic             r_s1_valid;
   logic [WIDTH-1:0] r_s1_a;
   logic [WIDTH-1:0] r_s1_b;
   logic [1:0]       r_s1_op;
   logic             r_s1_set_cc;
   logic             r_s2_set_cc;

   logic             w_s2_adv;
   logic             w_s1_adv;
   logic [WIDTH-1:0] w_res;
   logic             w_of;
   logic             w_zf;
   logic             w_sf;
   logic             w_a_sign;
   logic             w_b_sign;

   // Each stage moves when its downstream slot is empty or draining this cycle.
   assign w_s2_adv = !out_valid || out_ready;
   assign w_s1_adv = !r_s1_valid || w_s2_adv;
   assign in_ready = w_s1_adv;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_a      <= '0;
         r_s1_b      <= '0;
         r_s1_op     <= c_op_add;
         r_s1_set_cc <= 1'b0;
      end else if (w_s1_adv) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_a      <= num1;
            r_s1_b      <= num2;
            r_s1_op     <= operation;
            r_s1_set_cc <= set_cc;
         end
      end
   end

   assign w_a_sign = r_s1_a[WIDTH-1];
   assign w_b_sign = r_s1_b[WIDTH-1];

   always_comb begin
      w_res = '0;
      w_of  = 1'b0;
      case (r_s1_op)
         c_op_add: begin
            w_res = r_s1_a + r_s1_b;
            w_of  = (w_a_sign == w_b_sign) && (w_res[WIDTH-1] != w_a_sign);
         end
         c_op_sub: begin
            w_res = r_s1_a - r_s1_b;
            w_of  = (w_a_sign != w_b_sign) && (w_res[WIDTH-1] != w_a_sign);
         end
         c_op_and: w_res = r_s1_a & r_s1_b;
         c_op_xor: w_res = r_s1_a ^ r_s1_b;
         default:  w_res = '0;
      endcase
   end

   assign w_zf = (w_res == '0);
   assign w_sf = w_res[WIDTH-1];

   // Output registers only load on advance, so a stalled beat holds steady.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid     <= 1'b0;
         result        <= '0;
         overflow_flag <= 1'b0;
         zero_flag     <= 1'b0;
         sign_flag     <= 1'b0;
         r_s2_set_cc   <= 1'b0;
      end else if (w_s2_adv) begin
         out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            result        <= w_res;
            overflow_flag <= w_of;
            zero_flag     <= w_zf;
            sign_flag     <= w_sf;
            r_s2_set_cc   <= r_s1_set_cc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         {cc_zf, cc_sf, cc_of} <= CC_RESET;
      end else if (out_valid && out_ready && r_s2_set_cc) begin
         {cc_zf, cc_sf, cc_of} <= {zero_flag, sign_flag, overflow_flag};
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pipelined_alu_cc.sv
// ============================================================================
//  Module   : tb_pipelined_alu_cc
//  Purpose  : Self-checking bench for pipelined_alu_cc (64-bit and 8-bit).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipelined_alu_cc;

   localparam logic [2:0] CC_RST = 3'b100;

   typedef struct packed {
      logic [63:0] r;
      logic        of;
      logic        zf;
      logic        sf;
      logic        sc;
   } exp_t;

   typedef struct {
      logic [1:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic        sc;
      logic [63:0] r;
      logic        of;
      logic        zf;
      logic        sf;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready, set_cc;
   logic [63:0] num1, num2, result;
   logic [1:0]  operation;
   logic        overflow_flag, zero_flag, sign_flag, cc_zf, cc_sf, cc_of;

   logic        iv8, ir8, ov8, or8, sc8;
   logic [7:0]  a8, b8, r8;
   logic [1:0]  op8;
   logic        of8, zf8, sf8, czf8, csf8, cof8;

   int          n_vec  = 0;
   int          n_miss = 0;
   logic        mon_en = 1'b0;
   exp_t        q[$];
   exp_t        cur_exp;
   logic [2:0]  cc_model = CC_RST;

   always #5 clk = ~clk;

   pipelined_alu_cc #(.WIDTH(64), .CC_RESET(CC_RST)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .num1(num1), .num2(num2), .operation(operation), .set_cc(set_cc),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .overflow_flag(overflow_flag), .zero_flag(zero_flag), .sign_flag(sign_flag),
      .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
   );

   pipelined_alu_cc #(.WIDTH(8), .CC_RESET(CC_RST)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
      .num1(a8), .num2(b8), .operation(op8), .set_cc(sc8),
      .out_valid(ov8), .out_ready(or8), .result(r8),
      .overflow_flag(of8), .zero_flag(zf8), .sign_flag(sf8),
      .cc_zf(czf8), .cc_sf(csf8), .cc_of(cof8)
   );

   // Reference model: exact sum/difference in 65 bits, overflow when it does not fit.
   function automatic exp_t model(input logic [1:0] op, input logic [63:0] a,
                                  input logic [63:0] b, input logic sc);
      exp_t        e;
      logic [64:0] wide;
      wide = '0;
      e.of = 1'b0;
      case (op)
         2'b00:   begin wide = {a[63], a} + {b[63], b}; e.of = wide[64] ^ wide[63]; end
         2'b01:   begin wide = {a[63], a} - {b[63], b}; e.of = wide[64] ^ wide[63]; end
         2'b10:   wide = {1'b0, a & b};
         default: wide = {1'b0, a ^ b};
      endcase
      e.r  = wide[63:0];
      e.zf = (e.r == 64'd0);
      e.sf = e.r[63];
      e.sc = sc;
      return e;
   endfunction

   // Scoreboard: sampled mid-cycle; handshakes seen here complete on the next edge.
   always @(negedge clk) begin
      if (mon_en) begin
         n_vec++;
         if ({cc_zf, cc_sf, cc_of} !== cc_model) begin
            n_miss++;
            $display("FAIL cc got=%b exp=%b t=%0t", {cc_zf, cc_sf, cc_of}, cc_model, $time);
         end
         if (!rst_n) begin
            q.delete();
            cc_model = CC_RST;
         end else begin
            if (out_valid) begin
               n_vec++;
               if (q.size() == 0) begin
                  n_miss++;
                  $display("FAIL beat unexpected result=%h t=%0t", result, $time);
               end else begin
                  if ({result, overflow_flag, zero_flag, sign_flag} !==
                      {q[0].r, q[0].of, q[0].zf, q[0].sf}) begin
                     n_miss++;
                     $display("FAIL beat got=%h of%b zf%b sf%b exp=%h of%b zf%b sf%b t=%0t",
                              result, overflow_flag, zero_flag, sign_flag,
                              q[0].r, q[0].of, q[0].zf, q[0].sf, $time);
                  end
                  if (out_ready) begin
                     if (q[0].sc) cc_model = {q[0].zf, q[0].sf, q[0].of};
                     void'(q.pop_front());
                  end
               end
            end
            if (in_valid && in_ready) q.push_back(cur_exp);
         end
      end
   end

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the beat has been accepted.
   task automatic drive(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic sc, input exp_t e);
      logic acc;
      acc       = 1'b0;
      operation = op;
      num1      = a;
      num2      = b;
      set_cc    = sc;
      cur_exp   = e;
      in_valid  = 1'b1;
      for (int i = 0; i < 50 && !acc; i++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      if (!acc) begin
         n_vec++;
         n_miss++;
         $display("FAIL accept_timeout got=0 exp=1");
      end
   endtask

   task automatic drain();
      logic done;
      done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         if (q.size() == 0 && !out_valid) done = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      check("drain", {127'd0, done}, 128'd1);
   endtask

   task automatic run8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic sc, input logic [7:0] er, input logic eof,
                       input logic ezf, input logic esf, input logic [2:0] ecc);
      op8 = op; a8 = a; b8 = b; sc8 = sc; iv8 = 1'b1;
      @(posedge clk); #1;
      iv8 = 1'b0;
      check("w8_latency", {127'd0, ov8}, 128'd0);
      @(posedge clk); #1;
      check("w8_beat", {116'd0, ov8, r8, of8, zf8, sf8}, {116'd0, 1'b1, er, eof, ezf, esf});
      @(posedge clk); #1;
      check("w8_cc", {125'd0, czf8, csf8, cof8}, {125'd0, ecc});
   endtask

   vec_t vecs[8];

   initial begin
      vecs[0] = '{2'b00, -64'sd5, 64'd107, 1'b1, 64'd102, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1};
      vecs[2] = '{2'b01, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{2'b11, 64'h5A5A, 64'h5A5A, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{2'b10, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1,
                  64'h0F0F_0000_0F0F_0000, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{2'b01, 64'd3, 64'd3, 1'b1, 64'd0, 1'b0, 1'b1, 1'b0};
      vecs[6] = '{2'b00, -64'sd1, -64'sd1, 1'b0, -64'sd2, 1'b0, 1'b0, 1'b1};
      vecs[7] = '{2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; set_cc = 1'b0;
      num1 = '0; num2 = '0; operation = 2'b00; cur_exp = '0;
      iv8 = 1'b0; or8 = 1'b1; sc8 = 1'b0; a8 = '0; b8 = '0; op8 = 2'b00;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      check("reset_outputs", {59'd0, out_valid, result, overflow_flag, zero_flag, sign_flag},
            {59'd0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0});
      check("reset_cc", {125'd0, cc_zf, cc_sf, cc_of}, {125'd0, CC_RST});
      check("reset_in_ready", {126'd0, in_ready, ir8}, {126'd0, 2'b11});
      mon_en = 1'b1;

      // 8-bit corner cases: signed wrap on add and sub, zero via xor.
      run8(2'b00, 8'h7F, 8'h01, 1'b1, 8'h80, 1'b1, 1'b0, 1'b1, 3'b011);
      run8(2'b01, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b0, 1'b0, 3'b011);
      run8(2'b11, 8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'b011);

      // Table vectors streamed back to back.
      foreach (vecs[i]) begin
         exp_t e;
         e = '{vecs[i].r, vecs[i].of, vecs[i].zf, vecs[i].sf, vecs[i].sc};
         drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sc, e);
      end
      in_valid = 1'b0;
      drain();

      // Random stream with a 5-cycle output stall in the middle.
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               logic [1:0]  op;
               logic [63:0] a, b;
               logic        sc;
               op = 2'($urandom_range(0, 3));
               a  = {$urandom, $urandom};
               b  = {$urandom, $urandom};
               sc = 1'($urandom_range(0, 1));
               drive(op, a, b, sc, model(op, a, b, sc));
            end
            in_valid = 1'b0;
         end
         begin
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            check("stall_in_ready", {127'd0, in_ready}, 128'd0);
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();

      // Reset with two set_cc ops in flight: neither may emerge or touch cc.
      drive(2'b01, 64'd0, 64'd1, 1'b1, model(2'b01, 64'd0, 64'd1, 1'b1));
      drive(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1,
            model(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1));
      in_valid = 1'b0;
      rst_n    = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      check("rst_flush_out_valid", {127'd0, out_valid}, 128'd0);
      check("rst_flush_cc", {125'd0, cc_zf, cc_sf, cc_of}, {125'd0, CC_RST});
      check("rst_flush_in_ready", {127'd0, in_ready}, 128'd1);
      repeat (5) @(posedge clk);
      #1;
      check("rst_flush_quiet", {127'd0, out_valid}, 128'd0);

      mon_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
